// File: rtl/wb_arbiter_if.sv
// Bus bundle between four requesters, the round-robin arbiter and the
// downstream consumer of the granted word.
interface wb_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        req;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] data3;
  logic [3:0]        ack;
  logic [1:0]        sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output req, data0, data1, data2, data3, out_ready,
    input  ack, sel, out_valid, out_data
  );

  modport slave (
    input  req, data0, data1, data2, data3, out_ready,
    output ack, sel, out_valid, out_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Four-way round-robin arbiter: captures one requester word into a holding
// register and presents it downstream until accepted, then acks the source.
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4
) (
  input logic         clk,
  input logic         rst_n,
  wb_arbiter_if.slave bus
);

  localparam int SEL_W = $clog2(N_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_r;
  logic [SEL_W-1:0]  ptr_r;
  logic [SEL_W-1:0]  sel_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;

  logic [3:0]        rot_s;
  logic [SEL_W-1:0]  off_s;
  logic [SEL_W-1:0]  win_s;
  logic [DATA_W-1:0] win_data_s;
  logic [3:0]        ack_s;

  // Rotate requests so bit 0 is the requester at ptr, then pick the lowest set bit.
  always_comb begin
    rot_s = bus.req;
    case (ptr_r)
      2'd0:    rot_s = bus.req;
      2'd1:    rot_s = {bus.req[0],   bus.req[3:1]};
      2'd2:    rot_s = {bus.req[1:0], bus.req[3:2]};
      2'd3:    rot_s = {bus.req[2:0], bus.req[3]};
      default: rot_s = bus.req;
    endcase
    if (rot_s[0]) begin
      off_s = 2'd0;
    end else if (rot_s[1]) begin
      off_s = 2'd1;
    end else if (rot_s[2]) begin
      off_s = 2'd2;
    end else begin
      off_s = 2'd3;
    end
    win_s = ptr_r + off_s;
  end

  // Winner's data word, selected for capture.
  always_comb begin
    win_data_s = bus.data0;
    case (win_s)
      2'd0:    win_data_s = bus.data0;
      2'd1:    win_data_s = bus.data1;
      2'd2:    win_data_s = bus.data2;
      2'd3:    win_data_s = bus.data3;
      default: win_data_s = bus.data0;
    endcase
  end

  // Acceptance pulse: combinational so the requester sees it in the handshake cycle.
  always_comb begin
    if ((state_r == HOLD) && bus.out_ready) begin
      ack_s = 4'b0001 << sel_r;
    end else begin
      ack_s = 4'b0000;
    end
  end

  // Capture/hold FSM; ptr advances only on acceptance, sel persists in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= 2'd0;
      sel_r       <= 2'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (|bus.req) begin
            sel_r       <= win_s;
            out_data_r  <= win_data_s;
            out_valid_r <= 1'b1;
            state_r     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            ptr_r       <= sel_r + 2'd1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack       = ack_s;
  assign bus.sel       = sel_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table, directed corner cases and
// randomized traffic against a transaction-level reference model.
module tb_wb_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  wb_arbiter_if #(.DATA_W(32)) bus ();

  wb_arbiter #(.DATA_W(32), .N_REQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  ack;
    logic [1:0]  sel;
    logic        vld;
    logic [31:0] dat;
  } vec_t;

  vec_t        tbl [11];
  logic [31:0] td  [4];

  // reference model: transaction state only
  bit          m_hold;
  int          m_ptr;
  logic [1:0]  m_sel;
  logic [31:0] m_data;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 1'b0;
    m_ptr  = 0;
    m_sel  = 2'd0;
    m_data = 32'h0;
  endtask

  task automatic drive(input logic [3:0] r, input logic rdy);
    @(negedge clk);
    bus.req       = r;
    bus.out_ready = rdy;
    bus.data0     = td[0];
    bus.data1     = td[1];
    bus.data2     = td[2];
    bus.data3     = td[3];
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eack;
    eack = (m_hold && bus.out_ready) ? (4'b0001 << m_sel) : 4'b0000;
    chk({tag, ".ack"}, {28'h0, bus.ack}, {28'h0, eack});
    chk({tag, ".sel"}, {30'h0, bus.sel}, {30'h0, m_sel});
    chk({tag, ".vld"}, {31'h0, bus.out_valid}, {31'h0, m_hold});
    chk({tag, ".dat"}, bus.out_data, m_data);
  endtask

  task automatic tick();
    int w;
    @(posedge clk);
    if (m_hold) begin
      if (bus.out_ready) begin
        m_hold = 1'b0;
        m_ptr  = (int'(m_sel) + 1) % 4;
      end
    end else if (bus.req != 4'b0000) begin
      w      = pick(bus.req, m_ptr);
      m_sel  = 2'(w);
      m_data = td[w];
      m_hold = 1'b1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    td[0] = 32'hA5A5_0001;
    td[1] = 32'h1111_0002;
    td[2] = 32'h2222_0003;
    td[3] = 32'h3333_0004;

    //          req      rdy   ack      sel   vld   data
    tbl[0]  = '{4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 32'h0};
    tbl[1]  = '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 32'hA5A5_0001};
    tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 32'hA5A5_0001};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 32'hA5A5_0001};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 32'h1111_0002};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 32'h1111_0002};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 32'h2222_0003};
    tbl[7]  = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 32'h2222_0003};
    tbl[8]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 32'h3333_0004};
    tbl[9]  = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 32'h3333_0004};
    tbl[10] = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 32'hA5A5_0001};

    rst_n         = 1'b0;
    bus.req       = 4'b0000;
    bus.out_ready = 1'b0;
    bus.data0     = 32'h0;
    bus.data1     = 32'h0;
    bus.data2     = 32'h0;
    bus.data3     = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.vld", {31'h0, bus.out_valid}, 32'h0);
    chk("rst.ack", {28'h0, bus.ack}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // table: single transfer then round-robin sweep
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].req, tbl[i].rdy);
      chk($sformatf("tbl%0d.ack", i), {28'h0, bus.ack}, {28'h0, tbl[i].ack});
      chk($sformatf("tbl%0d.sel", i), {30'h0, bus.sel}, {30'h0, tbl[i].sel});
      chk($sformatf("tbl%0d.vld", i), {31'h0, bus.out_valid}, {31'h0, tbl[i].vld});
      chk($sformatf("tbl%0d.dat", i), bus.out_data, tbl[i].dat);
      tick();
    end

    // hold stability while the source word changes (ptr=1 here)
    td[2] = 32'h0000_00C2;
    drive(4'b0100, 1'b0);
    tick();
    td[2] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      drive(4'b0100, 1'b0);
      chk("hold.dat", bus.out_data, 32'h0000_00C2);
      chk("hold.ack", {28'h0, bus.ack}, 32'h0);
      chk("hold.vld", {31'h0, bus.out_valid}, 32'h1);
      tick();
    end
    drive(4'b0100, 1'b1);
    chk("hold.acc", {28'h0, bus.ack}, 32'h4);
    tick();

    // wrap: ptr=3, req 0101 -> 0 then 2
    drive(4'b0101, 1'b0);
    tick();
    drive(4'b0101, 1'b1);
    chk("wrap.sel0", {30'h0, bus.sel}, 32'h0);
    chk("wrap.ack0", {28'h0, bus.ack}, 32'h1);
    tick();
    drive(4'b0101, 1'b0);
    tick();
    drive(4'b0101, 1'b1);
    chk("wrap.sel2", {30'h0, bus.sel}, 32'h2);
    chk("wrap.ack2", {28'h0, bus.ack}, 32'h4);
    tick();

    // grantee drops req during hold (ptr=3)
    drive(4'b0010, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(4'b0000, 1'b0);
      chk("drop.vld", {31'h0, bus.out_valid}, 32'h1);
      chk("drop.ack", {28'h0, bus.ack}, 32'h0);
      tick();
    end
    drive(4'b0000, 1'b1);
    chk("drop.acc", {28'h0, bus.ack}, 32'h2);
    tick();
    drive(4'b0000, 1'b1);
    chk("drop.once", {28'h0, bus.ack}, 32'h0);
    chk("drop.idle", {31'h0, bus.out_valid}, 32'h0);
    tick();

    // asynchronous reset during hold with sel=1 (ptr=2)
    drive(4'b0010, 1'b0);
    tick();
    drive(4'b0010, 1'b0);
    chk("ar.pre.sel", {30'h0, bus.sel}, 32'h1);
    chk("ar.pre.vld", {31'h0, bus.out_valid}, 32'h1);
    #2;
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("ar.vld", {31'h0, bus.out_valid}, 32'h0);
    chk("ar.sel", {30'h0, bus.sel}, 32'h0);
    chk("ar.dat", bus.out_data, 32'h0);
    chk("ar.ack", {28'h0, bus.ack}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    check_model("ar.rel");
    tick();
    drive(4'b0010, 1'b1);
    chk("ar.regrant.sel", {30'h0, bus.sel}, 32'h1);
    chk("ar.regrant.ack", {28'h0, bus.ack}, 32'h2);
    tick();

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < 4; j++) td[j] = $urandom;
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      check_model("rnd");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, width of each requester data word and of out_data.
REQ-002 Parameter: N_REQ, fixed at 4, number of requesters; select width is 2 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  4  per-requester request; bit i means requester i has a word pending on data_i.
REQ-006 data0, data1, data2, data3  input  DATA_W each  requester data words.
REQ-007 ack  output  4  one-hot, single-cycle pulse; bit i means requester i's word was accepted downstream.
REQ-008 sel  output  2  index of the current grantee; also drives the external 4:1 mux select.
REQ-009 out_valid  output  1  out_data holds a granted word awaiting acceptance.
REQ-010 out_data  output  DATA_W  registered copy of the granted requester's word.
REQ-011 out_ready  input  1  downstream accepts out_data when out_valid and out_ready are both high.

Function
REQ-012 Two-state FSM: IDLE (no word held) and HOLD (word held, out_valid=1).
REQ-013 IDLE with req==0: remain in IDLE; outputs unchanged; ack=0.
REQ-014 IDLE with req!=0: winner = first set bit scanning ptr, ptr+1, ... mod 4; sel<=winner; out_data<=data_winner; out_valid<=1; go to HOLD on the same edge.
REQ-015 HOLD with out_ready=0: sel, out_data and out_valid held stable regardless of changes on req or data inputs.
REQ-016 HOLD with out_ready=1: ack[sel]=1 combinationally in that cycle; out_valid<=0; ptr<=(sel+1) mod 4; go to IDLE.
REQ-017 ack is asserted only in a HOLD cycle with out_ready=1; at most one bit set; zero in all other cycles.
REQ-018 Throughput: at most one transfer per 2 cycles (mandatory IDLE bubble); first out_valid appears 1 cycle after req is sampled in IDLE.
REQ-019 Requesters hold req and data stable until ack; the arbiter masks nothing else, so the one-cycle bubble guarantees an acked requester is not regranted on a stale req.
REQ-020 If the grantee drops req during HOLD (protocol violation), the captured word still completes and is acked normally.
REQ-021 Fairness: round-robin over all four; a continuously requesting requester is granted within 4 transfers.
REQ-022 ptr wraps 3->0; ptr changes only on acceptance, never on capture.
REQ-023 sel persists after acceptance until the next capture, so the external mux keeps its last selection in IDLE.

Reset
REQ-024 rst_n low asynchronously forces state=IDLE, ptr=0, sel=0, out_valid=0, out_data=0; ack=0 while in reset.
REQ-025 Reset during HOLD discards the held word with no ack; the requester's req remains high and it is re-arbitrated from ptr=0 after release.
REQ-026 First rising clk edge with rst_n high may capture a request.

Verification
REQ-027 Reset then req=4'b0001, data0=32'hA5A5_0001, out_ready=1 -> cycle 1 out_valid=1, sel=0, out_data=32'hA5A5_0001; cycle 2 ack=4'b0001, then out_valid=0.
REQ-028 req=4'b1111 held, out_ready=1, ack'ed requesters re-raise req -> grant order 0,1,2,3,0 with ack on every other cycle.
REQ-029 Capture data2=32'h0000_00C2 with out_ready=0 for 5 cycles while data2 changes to 32'hDEAD_BEEF -> out_data stays 32'h0000_00C2, ack=0, then one ack=4'b0100 on out_ready=1.
REQ-030 ptr=3 after granting 2, req=4'b0101 -> winner 0 (wrap), next winner 2.
REQ-031 Assert rst_n=0 mid-cycle during HOLD with sel=1 -> out_valid, sel, out_data drop to 0 immediately without clk edge; no ack; after release req=4'b0010 regranted.
REQ-032 Grantee drops req during HOLD, out_ready rises 2 cycles later -> transfer completes with single ack pulse for that requester.
